// File: rtl/stage_writeback_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes,
// instruction type codes and the default datapath width.
package stage_writeback_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] INSTR_TYPE_ALU    = 3'd0;
  localparam logic [2:0] INSTR_TYPE_LOAD   = 3'd1;
  localparam logic [2:0] INSTR_TYPE_STORE  = 3'd2;
  localparam logic [2:0] INSTR_TYPE_BRANCH = 3'd3;
  localparam logic [2:0] INSTR_TYPE_JUMP   = 3'd4;
  localparam logic [2:0] INSTR_TYPE_SYSTEM = 3'd5;

endpackage

// File: rtl/stage_writeback_load_align.sv
// Load aligner: picks the addressed byte/halfword out of a raw memory word,
// extends it, and flags accesses that are not naturally aligned.
module load_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);
  import stage_writeback_pkg::*;

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Select the addressed byte and halfword from the raw word
  always_comb begin
    case (offset)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = offset[1] ? word[31:16] : word[15:0];
  end

  // Extend according to the load width; unknown codes behave like a word load
  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      LB:  data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      LBU: data = {{(XLEN-8){1'b0}}, sel_byte};
      LH: begin
        data       = {{(XLEN-16){sel_half[15]}}, sel_half};
        misaligned = offset[0];
      end
      LHU: begin
        data       = {{(XLEN-16){1'b0}}, sel_half};
        misaligned = offset[0];
      end
      default: begin
        data       = word;
        misaligned = (offset != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/stage_writeback.sv
// Pipeline stage 5: aligns load data, queues results in a small FIFO and
// drains the head to the register file and ROB under the ROB handshake.
module stage_writeback #(
  parameter int DEPTH     = 2,
  parameter int XLEN      = stage_writeback_pkg::XLEN,
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_cache_stall,
  input  logic [XLEN-1:0]      in_alu_out,
  input  logic [XLEN-1:0]      in_read_data,
  input  logic [2:0]           in_funct3,
  input  logic [4:0]           in_rd,
  input  logic                 in_mem_to_reg,
  input  logic                 in_write_enable,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [2:0]           in_instr_type,
  input  logic                 in_flush,
  input  logic                 in_rob_ready,
  output logic                 out_ready,
  output logic                 out_rf_write_en,
  output logic [4:0]           out_rf_rd,
  output logic [XLEN-1:0]      out_rf_data,
  output logic                 out_rob_valid,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  output logic [XLEN-1:0]      out_rob_data,
  output logic                 out_rob_exception,
  output logic                 out_fwd_valid,
  output logic [4:0]           out_fwd_rd,
  output logic [XLEN-1:0]      out_fwd_data
);
  import stage_writeback_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [XLEN-1:0]      mem_data [DEPTH];
  logic [4:0]           mem_rd   [DEPTH];
  logic                 mem_we   [DEPTH];
  logic [ROB_IDX_W-1:0] mem_idx  [DEPTH];
  logic                 mem_exc  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [XLEN-1:0] aligned_data;
  logic            misaligned;
  logic            new_exc;
  logic [XLEN-1:0] new_data;
  logic            new_we;
  logic            empty;
  logic            push;
  logic            pop;
  logic            head_fwd;

  // The instruction type is carried upstream but not needed at this stage
  logic unused_instr_type;
  assign unused_instr_type = ^in_instr_type;

  load_align #(.XLEN(XLEN)) u_load_align (
    .word       (in_read_data),
    .offset     (in_alu_out[1:0]),
    .funct3     (in_funct3),
    .data       (aligned_data),
    .misaligned (misaligned)
  );

  // Build the entry: faulting loads report their address and never write rd
  always_comb begin
    new_exc  = in_mem_to_reg && misaligned;
    new_data = (in_mem_to_reg && !misaligned) ? aligned_data : in_alu_out;
    new_we   = in_write_enable && !new_exc;
  end

  // Handshake decode from registered occupancy only
  always_comb begin
    empty     = (count == '0);
    out_ready = (count < DEPTH_C);
    push      = in_valid && !in_cache_stall && out_ready;
    pop       = !empty && in_rob_ready;
  end

  // Entry storage; contents are don't-care until pushed, so no reset here
  always_ff @(posedge clk) begin
    if (reset && !in_flush && push) begin
      mem_data[wr_ptr] <= new_data;
      mem_rd[wr_ptr]   <= in_rd;
      mem_we[wr_ptr]   <= new_we;
      mem_idx[wr_ptr]  <= in_rob_idx;
      mem_exc[wr_ptr]  <= new_exc;
    end
  end

  // Pointer and occupancy bookkeeping; flush discards everything
  always_ff @(posedge clk) begin
    if (!reset || in_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head outputs are zeroed whenever the FIFO is empty
  always_comb begin
    head_fwd          = !empty && mem_we[rd_ptr] && (mem_rd[rd_ptr] != 5'd0) && !mem_exc[rd_ptr];
    out_rob_valid     = !empty;
    out_rob_idx       = empty ? '0 : mem_idx[rd_ptr];
    out_rob_data      = empty ? '0 : mem_data[rd_ptr];
    out_rob_exception = !empty && mem_exc[rd_ptr];
    out_rf_write_en   = head_fwd && in_rob_ready;
    out_rf_rd         = empty ? 5'd0 : mem_rd[rd_ptr];
    out_rf_data       = empty ? '0 : mem_data[rd_ptr];
    out_fwd_valid     = head_fwd;
    out_fwd_rd        = empty ? 5'd0 : mem_rd[rd_ptr];
    out_fwd_data      = empty ? '0 : mem_data[rd_ptr];
  end

endmodule

// File: tb/tb_stage_writeback.sv
// Self-checking bench for stage_writeback: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_stage_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_cache_stall;
  logic [31:0] in_alu_out;
  logic [31:0] in_read_data;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        in_mem_to_reg;
  logic        in_write_enable;
  logic [3:0]  in_rob_idx;
  logic [2:0]  in_instr_type;
  logic        in_flush;
  logic        in_rob_ready;
  logic        out_ready;
  logic        out_rf_write_en;
  logic [4:0]  out_rf_rd;
  logic [31:0] out_rf_data;
  logic        out_rob_valid;
  logic [3:0]  out_rob_idx;
  logic [31:0] out_rob_data;
  logic        out_rob_exception;
  logic        out_fwd_valid;
  logic [4:0]  out_fwd_rd;
  logic [31:0] out_fwd_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic [3:0]  idx;
    logic        exc;
  } ent_t;

  ent_t model_q[$];

  stage_writeback #(.DEPTH(DEPTH), .XLEN(32), .ROB_IDX_W(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_cache_stall    (in_cache_stall),
    .in_alu_out        (in_alu_out),
    .in_read_data      (in_read_data),
    .in_funct3         (in_funct3),
    .in_rd             (in_rd),
    .in_mem_to_reg     (in_mem_to_reg),
    .in_write_enable   (in_write_enable),
    .in_rob_idx        (in_rob_idx),
    .in_instr_type     (in_instr_type),
    .in_flush          (in_flush),
    .in_rob_ready      (in_rob_ready),
    .out_ready         (out_ready),
    .out_rf_write_en   (out_rf_write_en),
    .out_rf_rd         (out_rf_rd),
    .out_rf_data       (out_rf_data),
    .out_rob_valid     (out_rob_valid),
    .out_rob_idx       (out_rob_idx),
    .out_rob_data      (out_rob_data),
    .out_rob_exception (out_rob_exception),
    .out_fwd_valid     (out_fwd_valid),
    .out_fwd_rd        (out_fwd_rd),
    .out_fwd_data      (out_fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference result from the architectural load rules, using shifts/masks
  function automatic ent_t model_entry();
    ent_t e;
    int unsigned off;
    logic [31:0] b;
    logic [31:0] h;
    off = int'(in_alu_out[1:0]);
    b = (in_read_data >> (8 * off)) & 32'hFF;
    h = (in_read_data >> (16 * (off / 2))) & 32'hFFFF;
    e.exc  = 1'b0;
    e.data = in_alu_out;
    if (in_mem_to_reg) begin
      case (in_funct3)
        3'b000: e.data = (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
        3'b100: e.data = b;
        3'b001: if (off % 2 == 1) e.exc = 1'b1;
                else e.data = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
        3'b101: if (off % 2 == 1) e.exc = 1'b1;
                else e.data = h;
        default: if (off != 0) e.exc = 1'b1;
                 else e.data = in_read_data;
      endcase
      if (e.exc) e.data = in_alu_out;
    end
    e.rd  = in_rd;
    e.idx = in_rob_idx;
    e.we  = in_write_enable && !e.exc;
    return e;
  endfunction

  task automatic check_outputs();
    ent_t h;
    check("out_ready", {31'd0, out_ready}, {31'd0, model_q.size() < DEPTH});
    if (model_q.size() == 0) begin
      check("rob_valid_empty", {31'd0, out_rob_valid}, 32'd0);
      check("rf_we_empty", {31'd0, out_rf_write_en}, 32'd0);
      check("fwd_valid_empty", {31'd0, out_fwd_valid}, 32'd0);
      check("rob_exc_empty", {31'd0, out_rob_exception}, 32'd0);
      check("rob_data_empty", out_rob_data, 32'd0);
    end else begin
      h = model_q[0];
      check("rob_valid", {31'd0, out_rob_valid}, 32'd1);
      check("rob_idx", {28'd0, out_rob_idx}, {28'd0, h.idx});
      check("rob_data", out_rob_data, h.data);
      check("rob_exc", {31'd0, out_rob_exception}, {31'd0, h.exc});
      check("rf_we", {31'd0, out_rf_write_en},
            {31'd0, in_rob_ready && h.we && h.rd != 0 && !h.exc});
      check("rf_rd", {27'd0, out_rf_rd}, {27'd0, h.rd});
      check("rf_data", out_rf_data, h.data);
      check("fwd_valid", {31'd0, out_fwd_valid}, {31'd0, h.we && h.rd != 0 && !h.exc});
      check("fwd_rd", {27'd0, out_fwd_rd}, {27'd0, h.rd});
      check("fwd_data", out_fwd_data, h.data);
    end
  endtask

  // One clock: check before the edge, advance the model at the edge
  task automatic step();
    ent_t e;
    bit do_push;
    bit do_pop;
    @(negedge clk);
    check_outputs();
    do_push = in_valid && !in_cache_stall && (model_q.size() < DEPTH);
    do_pop  = (model_q.size() > 0) && in_rob_ready;
    e = model_entry();
    @(posedge clk);
    if (!reset || in_flush) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    #1;
  endtask

  task automatic drive_alu(input logic [31:0] value, input logic [4:0] rd, input logic [3:0] idx);
    in_valid = 1'b1; in_mem_to_reg = 1'b0; in_alu_out = value;
    in_rd = rd; in_rob_idx = idx; in_write_enable = 1'b1; in_funct3 = 3'b010;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    in_valid = 1'b1; in_mem_to_reg = 1'b1; in_alu_out = addr; in_funct3 = f3;
    in_read_data = 32'h8070_60F0; in_rd = rd; in_write_enable = 1'b1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_cache_stall = 1'b0; in_alu_out = '0;
    in_read_data = '0; in_funct3 = '0; in_rd = '0; in_mem_to_reg = 1'b0;
    in_write_enable = 1'b0; in_rob_idx = '0; in_instr_type = '0;
    in_flush = 1'b0; in_rob_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state
    check("reset_ready", {31'd0, out_ready}, 32'd1);
    check("reset_rob_valid", {31'd0, out_rob_valid}, 32'd0);
    check("reset_rf_we", {31'd0, out_rf_write_en}, 32'd0);

    // LB sign extension of the top byte
    drive_load(3'b000, 32'h1003, 5'd5); in_rob_idx = 4'd3;
    step();
    in_valid = 1'b0;
    check("lb_rf_we", {31'd0, out_rf_write_en}, 32'd1);
    check("lb_rf_rd", {27'd0, out_rf_rd}, 32'd5);
    check("lb_rf_data", out_rf_data, 32'hFFFF_FF80);
    check("lb_rob_idx", {28'd0, out_rob_idx}, 32'd3);
    step();

    // LHU upper half
    drive_load(3'b101, 32'h1002, 5'd6);
    step();
    in_valid = 1'b0;
    check("lhu_data", out_rob_data, 32'h0000_8070);
    step();

    // Misaligned LH reports the faulting address
    drive_load(3'b001, 32'h1001, 5'd7);
    step();
    in_valid = 1'b0;
    check("lh_exc", {31'd0, out_rob_exception}, 32'd1);
    check("lh_rf_we", {31'd0, out_rf_write_en}, 32'd0);
    check("lh_data", out_rob_data, 32'h0000_1001);
    step();

    // Back-pressure and in-order drain; full FIFO refuses a same-cycle push
    in_rob_ready = 1'b0;
    drive_alu(32'h11, 5'd8, 4'd1); step();
    drive_alu(32'h22, 5'd9, 4'd2); step();
    check("bp_ready_low", {31'd0, out_ready}, 32'd0);
    check("bp_head_11", out_rob_data, 32'h11);
    drive_alu(32'h33, 5'd10, 4'd3); step();
    check("bp_still_full", {31'd0, out_ready}, 32'd0);
    in_rob_ready = 1'b1;
    step();
    check("bp_ready_after_pop", {31'd0, out_ready}, 32'd1);
    check("bp_head_22", out_rob_data, 32'h22);
    step();
    in_valid = 1'b0;
    check("bp_head_33", out_rob_data, 32'h33);
    step();
    check("bp_drained", {31'd0, out_rob_valid}, 32'd0);

    // rd==0 result goes to the ROB only
    in_rob_ready = 1'b0;
    drive_alu(32'h55, 5'd0, 4'd4); step();
    in_valid = 1'b0;
    check("rd0_rob_valid", {31'd0, out_rob_valid}, 32'd1);
    check("rd0_rob_data", out_rob_data, 32'h55);
    check("rd0_rf_we", {31'd0, out_rf_write_en}, 32'd0);
    check("rd0_fwd", {31'd0, out_fwd_valid}, 32'd0);
    in_rob_ready = 1'b1; step();

    // Flush with two entries pending
    in_rob_ready = 1'b0;
    drive_alu(32'h66, 5'd11, 4'd5); step();
    drive_alu(32'h77, 5'd12, 4'd6); step();
    in_flush = 1'b1; step();
    in_flush = 1'b0; in_valid = 1'b0;
    check("flush_rob_valid", {31'd0, out_rob_valid}, 32'd0);
    check("flush_ready", {31'd0, out_ready}, 32'd1);

    // Reset with two entries pending
    drive_alu(32'h88, 5'd13, 4'd7); step();
    drive_alu(32'h99, 5'd14, 4'd8); step();
    reset = 1'b0; step();
    reset = 1'b1; in_valid = 1'b0; in_rob_ready = 1'b1;
    check("rst_rob_valid", {31'd0, out_rob_valid}, 32'd0);
    check("rst_rf_we", {31'd0, out_rf_write_en}, 32'd0);
    check("rst_rob_data", out_rob_data, 32'd0);
    check("rst_fwd_valid", {31'd0, out_fwd_valid}, 32'd0);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      reset           = ($urandom_range(0, 49) != 0);
      in_flush        = ($urandom_range(0, 19) == 0);
      in_valid        = $urandom_range(0, 1);
      in_cache_stall  = ($urandom_range(0, 3) == 0);
      in_alu_out      = $urandom;
      in_read_data    = $urandom;
      in_funct3       = 3'($urandom_range(0, 7));
      in_rd           = 5'($urandom_range(0, 31));
      in_mem_to_reg   = $urandom_range(0, 1);
      in_write_enable = ($urandom_range(0, 4) != 0);
      in_rob_idx      = 4'($urandom_range(0, 15));
      in_instr_type   = 3'($urandom_range(0, 7));
      in_rob_ready    = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_writeback.md
Name: stage_writeback

Overview:
- Stage 5 of the pipeline; consumes the cache stage's result bundle (ALU result, load data, rd and control bits, ROB index, instruction type).
- Performs load sign/zero extension and misalignment checking.
- Buffers results in a small FIFO and drains them to the register-file write port and the ROB result port under an ROB ready handshake.
- Exposes the head entry as a forwarding source; back-pressures the cache stage when full.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- XLEN, 32, datapath width.
- ROB_IDX_W, 4, ROB index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  cache stage presents a result
- in_cache_stall  in  1  cache stage busy; input bundle is not valid this cycle
- in_alu_out  in  XLEN  ALU result or effective address
- in_read_data  in  XLEN  raw 32-bit word from cache or store-buffer bypass
- in_funct3  in  3  load width/sign selector
- in_rd  in  5  destination register
- in_mem_to_reg  in  1  result comes from memory
- in_write_enable  in  1  instruction writes rd
- in_rob_idx  in  ROB_IDX_W  ROB entry of the instruction
- in_instr_type  in  3  instruction type code
- in_flush  in  1  ROB exception flush
- in_rob_ready  in  1  ROB accepts a result this cycle
- out_ready  out  1  FIFO can accept an entry
- out_rf_write_en  out  1  register-file write strobe
- out_rf_rd  out  5  register-file write address
- out_rf_data  out  XLEN  register-file write data
- out_rob_valid  out  1  result offered to ROB
- out_rob_idx  out  ROB_IDX_W  ROB index of the result
- out_rob_data  out  XLEN  result value
- out_rob_exception  out  1  misaligned load
- out_fwd_valid  out  1  head entry writes a nonzero rd
- out_fwd_rd  out  5  forwarding register
- out_fwd_data  out  XLEN  forwarding value

Behaviour:
- Reset (reset==0 at a clk edge): FIFO emptied; rd/wr pointers and count = 0. All valid/strobe outputs = 0; data/idx/rd outputs = 0. out_ready = 1 in the first cycle after reset.
- Push condition: in_valid && !in_cache_stall && out_ready. The extended entry is written at that clk edge.
- Entry contents: data, rd, we, rob_idx, exception.
- Entry data:
  - If in_mem_to_reg==1, data comes from the load aligner using offset in_alu_out[1:0].
  - LB: sign-extend byte[off]. LBU: zero-extend byte[off].
  - LH: sign-extend half[off[1]]. LHU: zero-extend half[off[1]].
  - LW: full word.
  - If in_mem_to_reg==0, data = in_alu_out.
- Misalignment:
  - Halfword load with off[0]==1, or LW with off!=0 → exception=1, we forced to 0, data = in_alu_out (faulting address).
  - Unknown funct3 on a load → treated as LW.
- Head outputs are combinational from the head entry.
  - out_rob_valid = !empty.
  - out_rf_write_en = !empty && in_rob_ready && we && rd!=0 && !exception.
  - Pop occurs when out_rob_valid && in_rob_ready.
- Latency: an accepted entry is visible at the head one cycle after push if the FIFO was empty. There is no combinational path from input to output.
- out_ready = (count < DEPTH).
  - Registered-state based; a same-cycle pop does not free a slot for a same-cycle push.
  - Push and pop in the same cycle keep count unchanged.
- Pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits wide.
- rd==0: ROB result still issued; register-file write suppressed; out_fwd_valid = 0.
- out_fwd_valid = !empty && we && rd!=0 && !exception. Forwarding is valid regardless of in_rob_ready.
- in_flush (highest priority after reset): all entries discarded at the edge and count = 0. A push and a pop in the same cycle as a flush are ignored; out_rob_valid is still shown combinationally that cycle but must be treated as void by the ROB.
- Reset mid-drain: entries are lost; no strobe is asserted in the reset cycle's outputs after the edge.
- Outputs are held stable while out_rob_valid && !in_rob_ready.

Decomposition:
- Shared package: funct3 load codes (LB=000, LH=001, LW=010, LBU=100, LHU=101), INSTR_TYPE_* codes, XLEN.
- Sub-module: load_align (combinational). Inputs are word, offset and funct3; outputs are data and misaligned.
- The FIFO is inline in stage_writeback.

Test Plan:
- LB, word 0x8070_60F0, addr 0x1003, rd=5, rob_idx=3, in_rob_ready=1 → next cycle out_rf_write_en=1, rd=5, data=0xFFFF_FF80; out_rob_idx=3.
- LHU, same word, addr 0x1002 → data 0x0000_8070. LH at addr 0x1001 → out_rob_exception=1, out_rf_write_en=0, out_rob_data=0x1001.
- in_rob_ready=0 while pushing 3 back-to-back ALU results (0x11, 0x22, 0x33), DEPTH=2:
  - out_ready drops after the 2nd push; the 3rd is held by upstream.
  - Raising ready drains 0x11, 0x22, 0x33 in order with no loss or duplication.
- Full FIFO with push and pop in the same cycle → push refused (out_ready=0), count goes 2→1; the next cycle accepts.
- ALU result to rd=0 → out_rob_valid=1 with data, out_rf_write_en=0, out_fwd_valid=0.
- Two entries pending, in_flush=1 → next cycle out_rob_valid=0, out_ready=1. Same sequence with reset=0 → all outputs 0 after the edge.
